led_pattern_sched: RTL
======================

# led_pattern_sched

LED pattern scheduler that drives the 8-bit board LED bank from three front-panel buttons. It selects one of four display patterns, sets the step rate, and can freeze stepping. It owns its own step prescaler and conditions its inputs with a synchronizer and debouncer. It sits between the top-level `btn` pins and `led` pins and replaces the free-running single-pattern LED rotator.

## Interface
- `TICK_DIV`, 2097152: clocks per pattern step at speed 0. Must be ≥ 8.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles needed to accept a button level. 10 ms at 25 MHz. Must be ≥ 1.
- `i_clk`  in  1  system clock (25 MHz).
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_btn_mode`  in  1  active-low raw button; press advances the pattern.
- `i_btn_speed`  in  1  active-low raw button; press advances the speed.
- `i_btn_hold`  in  1  active-low raw button; while held, stepping freezes.
- `o_led`  out  8  LED pattern.
- `o_mode`  out  2  current pattern: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK.
- `o_speed`  out  2  current speed index, 0..3.
- `o_tick`  out  1  one-cycle pulse, high in the cycle `o_led` shows a new step.

## Operation
- **Input conditioning**
  - Each button passes through a 2-flop synchronizer, reset to 1.
  - The debouncer then updates its accepted level only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts that count.
  - A press event is a one-cycle pulse on an accepted 1→0 transition. Releases generate no event.
- **Speed**
  - A speed press sets `o_speed` ← `o_speed`+1, wrapping 3→0.
  - Step period P = `TICK_DIV` >> `o_speed`.
- **Prescaler**
  - Counts 0..P-1. When it reaches P-1 it produces a step and returns to 0.
  - It clears to 0 on any mode or speed press.
  - It holds its value while the accepted hold level is 0.
- **Mode FSM** (states ROT_L → ROT_R → BOUNCE → BLINK → ROT_L, one advance per mode press)
  - On entry, `o_led` loads the seed: 8'h01 for ROT_L, ROT_R and BOUNCE; 8'h00 for BLINK.
  - On entry, bounce direction is set to left.
- **Step action per mode**
  - ROT_L: `o_led` ← {`o_led`[6:0], `o_led`[7]}.
  - ROT_R: `o_led` ← {`o_led`[0], `o_led`[7:1]}.
  - BOUNCE, direction left: if `o_led`[7], direction flips to right and `o_led` ← `o_led`>>1; otherwise `o_led` ← `o_led`<<1.
  - BOUNCE, direction right: mirror of the left case, flipping on `o_led`[0]. Sequence is 01,02,…,80,40,…,01,02 with no dwell at the ends.
  - BLINK: `o_led` ← ~`o_led`.
- **Hold**
  - No steps occur while held.
  - Mode and speed presses are still accepted; a mode press during hold still reloads the seed.
- **Simultaneous events**
  - Mode and speed press in the same cycle: both apply, seed reloads, prescaler clears.
  - A press coinciding with a step: the press wins, the step is discarded, and `o_tick` stays 0.
- **Reset (async)**
  - Outputs: `o_led`=8'h01, `o_mode`=0, `o_speed`=0, `o_tick`=0.
  - Internal: prescaler 0, direction left, synchronizers and accepted levels all 1 (released), debounce counters 0.
  - Reset mid-step or mid-debounce discards all pending state.

## Timing
- All outputs are registered. `o_tick` and the new `o_led` value appear on the same edge.
- First step after reset or a press: `o_tick` goes high P edges after the clearing edge. After that, steps repeat every P cycles.
- Press latency: the raw input is first sampled low at edge 0. The accepted level changes at edge `DEBOUNCE_CYCLES`+2. `o_mode`/`o_speed`/`o_led` update at edge `DEBOUNCE_CYCLES`+3.
- Hold latency matches press latency. The prescaler freezes from the edge after the accepted level goes low.
- A speed change takes effect on the next count. The counter is cleared, so there is no partial period.

## Configuration
- `LED_SCHED_DEBOUNCE_EN`
  - Defined: debouncer present, behaving as above.
  - Undefined: no debouncer; the accepted level equals the synchronized level. Press latency becomes 3 edges, and `DEBOUNCE_CYCLES` is ignored.

## Test plan
Bench parameters: `TICK_DIV`=16, `DEBOUNCE_CYCLES`=4, macro defined unless noted.
- Reset, no buttons → `o_led` steps 01,02,04,…,80,01 every 16 cycles. `o_tick` is a single-cycle pulse per step. `o_mode`=0.
- Speed pressed 3 times → periods 8, 4, 2 cycles. A 4th press wraps: `o_speed`=0, period 16.
- Mode pressed twice → BOUNCE, `o_led`=01, then 02,…,80,40,…,01,02. A 3rd press → BLINK: 00, FF, 00 alternating.
- Mode input bouncing low/high with a stable run of at most 3 cycles, then low for 4 cycles → exactly one mode advance, at edge 7 after the final low began.
- Hold low for 100 cycles in ROT_R → no `o_tick`, `o_led` constant. Mode press during hold → BOUNCE with `o_led`=01. Release → steps resume 16 cycles later.
- `i_rst` pulsed mid-BLINK at speed 2 → immediately `o_led`=01, mode 0, speed 0. Rebuild with the macro undefined → a press updates `o_mode` 3 edges after the low sample.

Source files
------------

// File: rtl/led_pattern_sched.sv
// ---------------------------------------------------------------------------
// led_pattern_sched
//
// Drives the 8-bit board LED bank from three active-low front-panel buttons.
// It selects one of four display patterns (rotate left, rotate right, bounce,
// blink), sets the step rate, and can freeze stepping while a button is held.
// It contains its own step prescaler. Each button input passes through a
// 2-flop synchronizer and, optionally, a debouncer.
//
// Parameters
//   TICK_DIV        clocks per pattern step at speed 0 (>= 8)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a button level
//                   (>= 1); ignored when the debouncer is not built
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_btn_mode   raw button, active low; each press advances the pattern
//   i_btn_speed  raw button, active low; each press advances the speed index
//   i_btn_hold   raw button, active low; stepping freezes while it is held
//   o_led        LED pattern (registered)
//   o_mode       current pattern: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   o_speed      current speed index 0..3; step period is TICK_DIV >> o_speed
//   o_tick       one-cycle pulse, high in the cycle o_led shows a new step
//
// Build option
//   LED_SCHED_DEBOUNCE_EN  defined: a debouncer follows each synchronizer.
//                          undefined: the accepted level is the synchronized
//                          level delayed by one register, so a press reaches
//                          the outputs 3 edges after the first low sample.
// ---------------------------------------------------------------------------
module led_pattern_sched #(
    parameter int unsigned TICK_DIV        = 2097152,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_speed,
    input  logic       i_btn_hold,
    output logic [7:0] o_led,
    output logic [1:0] o_mode,
    output logic [1:0] o_speed,
    output logic       o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Bit positions of the buttons inside the conditioning vectors.
    localparam int BTN_MODE  = 0;
    localparam int BTN_SPEED = 1;
    localparam int BTN_HOLD  = 2;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    typedef struct packed {
        dir_t       dir;
        logic [7:0] led;
    } pat_t;

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 8) begin : g_bad_tick_div
        $error("led_pattern_sched: TICK_DIV must be at least 8");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("led_pattern_sched: DEBOUNCE_CYCLES must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Last prescaler count of a step period: (TICK_DIV >> spd) - 1.
    function automatic logic [CNT_W-1:0] period_last(input logic [1:0] spd);
        int unsigned p;
        p = TICK_DIV >> spd;
        return CNT_W'(p - 32'd1);
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            ROT_L:   r = ROT_R;
            ROT_R:   r = BOUNCE;
            BOUNCE:  r = BLINK;
            default: r = ROT_L;
        endcase
        return r;
    endfunction

    // Pattern loaded when a mode is entered.
    function automatic logic [7:0] seed_led(input mode_t m);
        return (m == BLINK) ? 8'h00 : 8'h01;
    endfunction

    // One pattern step. Bounce turns around in the same step that reaches an
    // end, so the end LEDs are lit for a single step only.
    function automatic pat_t step_pattern(input mode_t m, input dir_t d,
                                          input logic [7:0] l);
        pat_t r;
        r.dir = d;
        r.led = l;
        case (m)
            ROT_L: r.led = {l[6:0], l[7]};
            ROT_R: r.led = {l[0], l[7:1]};
            BOUNCE: begin
                if (d == DIR_L) begin
                    if (l[7]) begin
                        r.dir = DIR_R;
                        r.led = l >> 1;
                    end else begin
                        r.led = l << 1;
                    end
                end else begin
                    if (l[0]) begin
                        r.dir = DIR_L;
                        r.led = l << 1;
                    end else begin
                        r.led = l >> 1;
                    end
                end
            end
            default: r.led = ~l;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] sync_p0;
    logic [2:0] sync_p1;
    logic [2:0] acc_lvl;
    logic [1:0] acc_prev;

    assign btn_raw = {i_btn_hold, i_btn_speed, i_btn_mode};

    // Synchronizer stages idle at 1 (buttons released).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_p0 <= 3'b111;
            sync_p1 <= 3'b111;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef LED_SCHED_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic [DB_W-1:0] db_cnt [3];

    // The counter runs while the synchronized level disagrees with the
    // accepted level; any agreeing cycle (a bounce) restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_lvl <= 3'b111;
            for (int b = 0; b < 3; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (sync_p1[b] != acc_lvl[b]) begin
                    if (db_cnt[b] == DB_MAX) begin
                        acc_lvl[b] <= sync_p1[b];
                        db_cnt[b]  <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_lvl <= 3'b111;
        end else begin
            acc_lvl <= sync_p1;
        end
    end
`endif

    // Previous accepted level for falling-edge (press) detection. Hold acts
    // on level only, so it needs no history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_prev <= 2'b11;
        end else begin
            acc_prev <= acc_lvl[BTN_SPEED:BTN_MODE];
        end
    end

    logic press_mode;
    logic press_speed;
    logic hold_active;

    assign press_mode  = acc_prev[BTN_MODE]  & ~acc_lvl[BTN_MODE];
    assign press_speed = acc_prev[BTN_SPEED] & ~acc_lvl[BTN_SPEED];
    assign hold_active = ~acc_lvl[BTN_HOLD];

    // -----------------------------------------------------------------------
    // Prescaler, mode FSM and pattern register
    // -----------------------------------------------------------------------
    mode_t            mode_q;
    dir_t             dir_q;
    logic [1:0]       speed_q;
    logic [7:0]       led_q;
    logic             tick_q;
    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] last_cnt;
    mode_t            mode_nxt;
    pat_t             step_nxt;

    assign last_cnt = period_last(speed_q);
    assign mode_nxt = next_mode(mode_q);
    assign step_nxt = step_pattern(mode_q, dir_q, led_q);

    // A press in the same cycle as a due step takes priority: the step is
    // dropped and the prescaler restarts from 0 for a full new period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q  <= ROT_L;
            dir_q   <= DIR_L;
            speed_q <= 2'd0;
            led_q   <= 8'h01;
            tick_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            tick_q <= 1'b0;
            if (press_mode || press_speed) begin
                presc_q <= '0;
                if (press_speed) begin
                    speed_q <= speed_q + 2'd1;
                end
                if (press_mode) begin
                    mode_q <= mode_nxt;
                    led_q  <= seed_led(mode_nxt);
                    dir_q  <= DIR_L;
                end
            end else if (!hold_active) begin
                if (presc_q == last_cnt) begin
                    presc_q <= '0;
                    tick_q  <= 1'b1;
                    led_q   <= step_nxt.led;
                    dir_q   <= step_nxt.dir;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign o_led   = led_q;
    assign o_mode  = mode_q;
    assign o_speed = speed_q;
    assign o_tick  = tick_q;

endmodule
